fact_engine: RTL and testbench

FACT_ENGINE -- requirements
Module: fact_engine

---
 rtl/fact_pkg.sv | 13 +
 rtl/fact_mul.sv | 26 ++
 rtl/fact_engine.sv | 140 ++++++++++++++
 tb/tb_fact_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and default widths for the scaled-factorial engine.
package fact_pkg;

    localparam int N_W_DEF   = 4;
    localparam int RES_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/fact_mul.sv
// Unsigned RES_W x (N_W+1) multiply, truncated, with an overflow bit.
// The overflow bit is only computed when FACT_OVF_EN is defined.
module fact_mul
    import fact_pkg::*;
#(
    parameter int A_W = RES_W_DEF,
    parameter int B_W = N_W_DEF + 1
) (
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [A_W-1:0] p_o,
    output logic           ovf_o
);

`ifdef FACT_OVF_EN
    logic [A_W+B_W-1:0] full;

    assign full  = a_i * b_i;
    assign p_o   = full[A_W-1:0];
    assign ovf_o = |full[A_W+B_W-1:A_W];
`else
    assign p_o   = a_i * {{(A_W-B_W){1'b0}}, b_i};
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/fact_engine.sv
// Iterative SCALE*n! engine, one multiply per cycle via a shared fact_mul.
// FACT_OVF_EN: saturate result and raise ovf when any product step overflows.
module fact_engine
    import fact_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int RES_W = RES_W_DEF,
    parameter int SCALE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             ovf
);

    localparam logic [N_W:0] SCALE_B = (N_W+1)'(SCALE);
    localparam logic [N_W:0] I_INIT  = (N_W+1)'(2);

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [N_W:0]       i_q, i_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   res_q, res_d;

    logic [N_W:0]       mul_b;
    logic [RES_W-1:0]   mul_p;
    logic               mul_ovf;

    // FIN reuses the multiplier for the final SCALE*acc step
    assign mul_b = (state_q == FIN) ? SCALE_B : i_q;

    fact_mul #(
        .A_W (RES_W),
        .B_W (N_W+1)
    ) u_mul (
        .a_i   (acc_q),
        .b_i   (mul_b),
        .p_o   (mul_p),
        .ovf_o (mul_ovf)
    );

`ifdef FACT_OVF_EN
    logic sticky_q, sticky_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        i_d     = i_q;
        done_d  = 1'b0;
        res_d   = res_q;
`ifdef FACT_OVF_EN
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n;
                    acc_d   = {{(RES_W-1){1'b0}}, 1'b1};
                    i_d     = I_INIT;
                    state_d = CALC;
`ifdef FACT_OVF_EN
                    sticky_d = 1'b0;
`endif
                end
            end
            CALC: begin
                if (i_q > {1'b0, n_q}) begin
                    state_d = FIN;
                end else begin
                    acc_d = mul_p;
                    i_d   = i_q + 1'b1;
`ifdef FACT_OVF_EN
                    sticky_d = sticky_q | mul_ovf;
`endif
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef FACT_OVF_EN
                if (sticky_q | mul_ovf) begin
                    res_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    res_d = mul_p;
                    ovf_d = 1'b0;
                end
`else
                res_d = mul_p;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
`ifdef FACT_OVF_EN
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            done_q  <= done_d;
            res_q   <= res_d;
`ifdef FACT_OVF_EN
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = res_q;
`ifdef FACT_OVF_EN
    assign ovf = ovf_q;
`else
    assign ovf = mul_ovf;
`endif

endmodule

// File: tb/tb_fact_engine.sv
// Scoreboard bench for fact_engine: directed cases plus random operands.
module tb_fact_engine;

    localparam int N_W   = 4;
    localparam int RES_W = 32;
    localparam int SCALE = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [N_W-1:0]   n = '0;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             ovf;

    fact_engine #(
        .N_W   (N_W),
        .RES_W (RES_W),
        .SCALE (SCALE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0] res;
        logic             o;
        int               nn;
        int               acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference: true SCALE*n! in 64-bit arithmetic, then wrap or saturate
    task automatic model(input int nn, output logic [RES_W-1:0] r,
                         output logic o);
        longint unsigned f = 1;
        for (int k = 2; k <= nn; k++) f = f * longint'(k);
        f = f * longint'(SCALE);
`ifdef FACT_OVF_EN
        if ((f >> RES_W) != 0) begin
            r = '1;
            o = 1'b1;
        end else begin
            r = RES_W'(f);
            o = 1'b0;
        end
`else
        r = RES_W'(f);
        o = 1'b0;
`endif
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic issue(input int nn, input bit hold,
                         input logic [RES_W-1:0] er, input logic eo);
        exp_t e;
        wait_idle();
        start = 1'b1;
        n = N_W'(nn);
        @(posedge clk);
        #1;
        e.res = er;
        e.o = eo;
        e.nn = nn;
        e.acc_cyc = cyc;
        sbq.push_back(e);
        if (!hold) start = 1'b0;
    endtask

    task automatic issue_model(input int nn, input bit hold);
        logic [RES_W-1:0] r;
        logic o;
        model(nn, r, o);
        issue(nn, hold, r, o);
    endtask

    logic             prev_done = 1'b0;
    logic [RES_W-1:0] last_res = '0;
    logic             last_ovf = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int lat;
        if (!reset) begin
            prev_done = 1'b0;
            last_res = '0;
            last_ovf = 1'b0;
        end else begin
            if (done) begin
                chk("done_single", 64'(prev_done), 64'd0);
                chk("busy_at_done", 64'(busy), 64'd0);
                if (sbq.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    lat = (e.nn > 1) ? e.nn + 1 : 2;
                    chk("result", 64'(result), 64'(e.res));
                    chk("ovf", 64'(ovf), 64'(e.o));
                    chk("latency", 64'(cyc - e.acc_cyc), 64'(lat));
                end
                last_res = result;
                last_ovf = ovf;
            end else begin
                chk("result_hold", 64'(result), 64'(last_res));
                chk("ovf_hold", 64'(ovf), 64'(last_ovf));
            end
            prev_done = done;
        end
    end

    initial begin
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(5, 0, 32'd240, 1'b0);
        issue(0, 1, 32'd2, 1'b0);
        issue(1, 0, 32'd2, 1'b0);
        issue(12, 0, 32'd958003200, 1'b0);
        issue_model(15, 0);
`ifdef FACT_OVF_EN
        issue(13, 0, 32'hFFFF_FFFF, 1'b1);
`else
        issue(13, 0, 32'd3864107008, 1'b0);
`endif

        issue(6, 0, 32'd1440, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        n = N_W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;

        issue(9, 0, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        sbq.delete();
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle", 64'(busy), 64'd0);
        end
        issue(3, 0, 32'd12, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            issue_model($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        start = 1'b0;

        begin
            int k = 0;
            while (sbq.size() != 0 && k < 300) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
